// File: rtl/collision_pair_scheduler_pkg.sv
// Shared types and default sizing for the collision pair scheduler.
package collision_pair_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_BALLS = 16;
  localparam int DEF_IDX_W     = 4;
  localparam int DEF_COOLDOWN  = 5;

endpackage

// File: rtl/collision_pair_scheduler_pair_iterator.sv
// Walks the upper-triangle ball pairs (i<j) in row-major order; holds on the final pair.
module pair_iterator
  import collision_pair_scheduler_pkg::*;
#(
  parameter int NUM_BALLS = DEF_NUM_BALLS,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);

  assign last = (i == LAST_I) && (j == LAST_J);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      j <= '0;
    end else if (init) begin
      i <= '0;
      j <= IDX_W'(1);
    end else if (advance && !last) begin
      if (j < LAST_J) begin
        j <= j + 1'b1;
      end else begin
        i <= i + 1'b1;
        j <= i + IDX_W'(2);
      end
    end
  end

endmodule

// File: rtl/collision_pair_scheduler.sv
// Per-frame scheduler feeding ball pairs to a shared collision checker, with per-ball cooldown.
// Optional build macro POCKET_SKIP_EN: also skip pairs whose balls are off the table (ball_active).
module collision_pair_scheduler
  import collision_pair_scheduler_pkg::*;
#(
  parameter int NUM_BALLS = DEF_NUM_BALLS,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int COOLDOWN  = DEF_COOLDOWN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_BALLS-1:0] ball_active,
  output logic                 req_valid,
  output logic [IDX_W-1:0]     req_a,
  output logic [IDX_W-1:0]     req_b,
  input  logic                 req_ready,
  input  logic                 resp_valid,
  input  logic                 resp_collided,
  output logic                 hit_valid,
  output logic [IDX_W-1:0]     hit_a,
  output logic [IDX_W-1:0]     hit_b,
  output logic                 busy,
  output logic                 scan_done,
  output logic                 overrun
);

  localparam logic [2:0] CD_LOAD = 3'(COOLDOWN);

  state_t               state;
  logic [2:0]           cooldown [NUM_BALLS];
  logic [NUM_BALLS-1:0] lock;
  logic [IDX_W-1:0]     pair_i;
  logic [IDX_W-1:0]     pair_j;
  logic                 pair_last;
  logic                 eligible;
  logic                 iter_init;
  logic                 iter_advance;

  always_comb begin
    eligible = (cooldown[pair_i] == 3'd0) && (cooldown[pair_j] == 3'd0) &&
               !lock[pair_i] && !lock[pair_j];
`ifdef POCKET_SKIP_EN
    eligible = eligible && ball_active[pair_i] && ball_active[pair_j];
`endif
  end

`ifndef POCKET_SKIP_EN
  logic unused_ball_active;
  assign unused_ball_active = ^ball_active;
`endif

  // The iterator moves on skipped pairs in SCAN and on every checker response in WAIT.
  assign iter_init    = (state == IDLE) && frame_tick;
  assign iter_advance = ((state == SCAN) && !req_valid && !eligible) ||
                        ((state == WAIT) && resp_valid);

  pair_iterator #(
    .NUM_BALLS (NUM_BALLS),
    .IDX_W     (IDX_W)
  ) u_pair_iterator (
    .clk     (clk),
    .reset   (reset),
    .init    (iter_init),
    .advance (iter_advance),
    .i       (pair_i),
    .j       (pair_j),
    .last    (pair_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_a     <= '0;
      req_b     <= '0;
      hit_valid <= 1'b0;
      hit_a     <= '0;
      hit_b     <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      overrun   <= 1'b0;
      lock      <= '0;
      for (int k = 0; k < NUM_BALLS; k++) cooldown[k] <= 3'd0;
    end else begin
      hit_valid <= 1'b0;
      scan_done <= 1'b0;
      overrun   <= frame_tick && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (frame_tick) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
              if (cooldown[k] != 3'd0) cooldown[k] <= cooldown[k] - 3'd1;
            end
            lock  <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        // Requests are launched one cycle after the pair is found eligible and held until accepted.
        SCAN: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              state     <= WAIT;
            end
          end else if (eligible) begin
            req_valid <= 1'b1;
            req_a     <= pair_i;
            req_b     <= pair_j;
          end else if (pair_last) begin
            busy      <= 1'b0;
            scan_done <= 1'b1;
            state     <= DONE;
          end
        end
        // Reloads only happen here, never alongside the IDLE decrement, so a reload always wins.
        WAIT: begin
          if (resp_valid) begin
            if (resp_collided) begin
              hit_valid        <= 1'b1;
              hit_a            <= pair_i;
              hit_b            <= pair_j;
              cooldown[pair_i] <= CD_LOAD;
              cooldown[pair_j] <= CD_LOAD;
              lock[pair_i]     <= 1'b1;
              lock[pair_j]     <= 1'b1;
            end
            if (pair_last) begin
              busy      <= 1'b0;
              scan_done <= 1'b1;
              state     <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Directed scoreboard bench for collision_pair_scheduler with four balls.
module tb_collision_pair_scheduler;

  localparam int NB = 4;
  localparam int IW = 2;
  localparam int CD = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic [NB-1:0] ball_active;
  logic          req_valid;
  logic [IW-1:0] req_a;
  logic [IW-1:0] req_b;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_collided;
  logic          hit_valid;
  logic [IW-1:0] hit_a;
  logic [IW-1:0] hit_b;
  logic          busy;
  logic          scan_done;
  logic          overrun;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_req [$];
  logic [3:0] exp_hit [$];
  logic       collide_en;
  logic [3:0] collide_pair;
  logic       stray;
  logic       rsp_hs;
  logic [3:0] rsp_pair;

  always #5 clk = ~clk;

  collision_pair_scheduler #(
    .NUM_BALLS (NB),
    .IDX_W     (IW),
    .COOLDOWN  (CD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .ball_active   (ball_active),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_collided (resp_collided),
    .hit_valid     (hit_valid),
    .hit_a         (hit_a),
    .hit_b         (hit_b),
    .busy          (busy),
    .scan_done     (scan_done),
    .overrun       (overrun)
  );

  function automatic logic [3:0] pr(int a, int b);
    return {a[1:0], b[1:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_all();
    for (int a = 0; a < NB - 1; a++)
      for (int b = a + 1; b < NB; b++) exp_req.push_back(pr(a, b));
  endtask

  task automatic start_frame();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
    chk("busy_in_scan", {busy, overrun}, 2'b10);
  endtask

  task automatic wait_done(string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (scan_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_queue"}, exp_req.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {scan_done, busy}, 0);
  endtask

  task automatic wait_handshake(string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (req_valid && req_ready) seen = 1'b1;
    end
    chk({tag, "_handshake"}, seen, 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; frame_tick = 1'b0; req_ready = 1'b1; resp_valid = 1'b0;
    resp_collided = 1'b0; ball_active = '1; collide_en = 1'b0;
    collide_pair = '0; stray = 1'b0;

    fork
      forever begin : responder
        @(negedge clk);
        rsp_hs   = req_valid && req_ready;
        rsp_pair = {req_a, req_b};
        @(posedge clk); #1;
        resp_valid    = rsp_hs || stray;
        resp_collided = (rsp_hs && collide_en && rsp_pair == collide_pair) || stray;
      end
      forever begin : monitor
        @(negedge clk);
        if (req_valid) chk("req_order", req_a < req_b, 1);
        if (req_valid && req_ready) begin
          if (exp_req.size() == 0) chk("unexpected_req", {req_a, req_b}, 32'hff);
          else chk("req_pair", {req_a, req_b}, exp_req.pop_front());
        end
        if (hit_valid) begin
          if (exp_hit.size() == 0) chk("unexpected_hit", {hit_a, hit_b}, 32'hff);
          else chk("hit_pair", {hit_a, hit_b}, exp_hit.pop_front());
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {req_valid, hit_valid, scan_done, overrun, busy}, 0);
    chk("rst_idx", {req_a, req_b, hit_a, hit_b}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // full scan, never collided
    push_all();
    start_frame();
    wait_done("scan_basic");

    // checker response outside WAIT
    @(negedge clk); #2 stray = 1'b1;
    @(posedge clk); #3 stray = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stray_resp", {hit_valid, busy, req_valid}, 0);

    // collision on (0,2), then cooldown frames with an overrun tick in frame 2
    collide_en = 1'b1; collide_pair = pr(0, 2);
    exp_req.push_back(pr(0, 1)); exp_req.push_back(pr(0, 2)); exp_req.push_back(pr(1, 3));
    exp_hit.push_back(pr(0, 2));
    start_frame();
    wait_done("cd_f1");
    collide_en = 1'b0;
    chk("hit_queue_f1", exp_hit.size(), 0);
    for (int f = 2; f <= 5; f++) begin
      exp_req.push_back(pr(1, 3));
      start_frame();
      if (f == 2) begin
        wait_handshake("overrun");
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(negedge clk);
        chk("overrun_pulse", overrun, 1);
        @(negedge clk);
        chk("overrun_one", overrun, 0);
      end
      wait_done("cd_frame");
    end
    push_all();
    start_frame();
    wait_done("cd_f6");

    // checker back-pressure on the first request
    req_ready = 1'b0;
    push_all();
    start_frame();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (req_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("stall_req_seen", seen, 1);
    for (int t = 0; t < 10; t++) begin
      chk("stall_valid", req_valid, 1);
      chk("stall_pair", {req_a, req_b}, pr(0, 1));
      if (t < 9) @(negedge clk);
    end
    @(posedge clk); #1 req_ready = 1'b1;
    wait_done("stall");

    // reset while waiting for the checker
    exp_req.push_back(pr(0, 1));
    start_frame();
    wait_handshake("rst_wait");
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("rst_wait_ctrl", {req_valid, hit_valid, scan_done, overrun, busy}, 0);
    chk("rst_wait_idx", {req_a, req_b, hit_a, hit_b}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_wait_quiet", {hit_valid, scan_done, busy}, 0);
    @(posedge clk); #1 reset = 1'b0;
    push_all();
    start_frame();
    wait_done("after_reset");

    // ball 1 pocketed
    ball_active = 4'b1101;
`ifdef POCKET_SKIP_EN
    exp_req.push_back(pr(0, 2)); exp_req.push_back(pr(0, 3)); exp_req.push_back(pr(2, 3));
`else
    push_all();
`endif
    start_frame();
    wait_done("ball_active");
    ball_active = '1;

    chk("hit_queue_end", exp_hit.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
